some_sub_module: RTL and testbench
==================================

Name: some_sub_module

Overview:
- Windowed sample statistics unit. Accepts 4-bit unsigned samples on input `c`, qualified by strobe `a`.
- After every N_SAMPLES accepted samples it publishes the window sum, maximum and minimum with a one-cycle valid pulse.
- Input `b` is a synchronous abort/clear.
- Sits as a leaf submodule under the parent datapath, fed directly from its `a`/`b`/`c` signals.

Parameters:
- W_ACC, default 12: width of the sum accumulator and `o_sum`; legal range ≥ 4.
- N_SAMPLES, default 8: samples per window; legal range ≥ 1, ≤ 255.

Ports:
- i_clk, input, 1: single clock; all state updates on its rising edge.
- i_rst, input, 1: asynchronous, active-high reset.
- a, input, 1: sample strobe; `c` is accepted on a rising edge where a=1 and b=0.
- b, input, 1: synchronous clear; aborts the current window and clears the sticky overflow.
- c, input, 4: unsigned sample data.
- o_sum, output, W_ACC: sum of the last completed window (saturating).
- o_max, output, 4: maximum sample of the last completed window.
- o_min, output, 4: minimum sample of the last completed window.
- o_valid, output, 1: one-cycle pulse when `o_sum`/`o_max`/`o_min` update.
- o_busy, output, 1: high while a window is partially filled (state ACC).
- o_overflow, output, 1: sticky; set when any window sum saturated.

Behaviour:
- Reset (i_rst=1, asynchronous): state IDLE, sample counter 0, running sum/max/min 0, all outputs 0. Release is synchronous to i_clk.
- FSM states are IDLE and ACC. `o_busy` = (state==ACC), decoded from the registered state.
- Priority at each edge: i_rst > b > a.
- b=1:
  - state→IDLE, counter and running registers cleared.
  - `o_valid`=0, `o_overflow` cleared.
  - Published `o_sum`/`o_max`/`o_min` keep their last values.
  - A simultaneous a=1 sample is discarded.
- IDLE, a=1:
  - Running sum=c, max=c, min=c, counter=1.
  - Go to ACC, unless N_SAMPLES==1, in which case the window completes on this edge.
- ACC, a=1:
  - sum += c (saturating), max=max(max,c), min=min(min,c), counter+1.
- a=0: no state change; gaps between samples are allowed without limit.
- Window completion, on the edge accepting the Nth sample:
  - Final sum/max/min (including that sample) are registered into the outputs.
  - `o_valid`=1 for exactly the following cycle.
  - State→IDLE, counter=0.
- Latency: outputs and `o_valid` become visible one cycle after the edge that captured the Nth sample.
- Back-to-back windows: a=1 in the cycle `o_valid` is high is accepted as sample 1 of the next window. There are no dead cycles.
- Arithmetic:
  - `c` is zero-extended to W_ACC.
  - If sum+c exceeds 2^W_ACC−1, the sum clamps to all-ones and `o_overflow` is set. It stays set until b=1 or reset.
  - Saturation persists for the rest of the window.
- `o_valid` is never asserted by b, by reset, or by a partial window.
- Outputs hold between completions.

Test Plan:
1. Reset mid-window: after 3 samples assert i_rst asynchronously → all outputs 0 immediately, `o_busy`=0. After release, an 8-sample window completes normally.
2. Default params, a=1 for 8 consecutive cycles with c=1..8 → `o_valid` pulses one cycle after the 8th edge; o_sum=36, o_max=8, o_min=1, o_busy falls with it.
3. Gapped strobe: samples 15,0,7,7,7,7,7,7 with a=0 idle cycles interleaved → o_sum=57, o_max=15, o_min=0; exactly one `o_valid` pulse.
4. Abort: 5 samples then b=1 together with a=1 → no `o_valid`, `o_busy`=0, previous outputs unchanged. The next 8 samples of value 2 → o_sum=16.
5. Saturation with W_ACC=6: 8 samples of 15 → o_sum=63, o_overflow=1 and stays 1 through the next window. A b=1 pulse clears it.
6. Back-to-back with N_SAMPLES=1: a held high with c=3,9,4 → `o_valid` high for three consecutive cycles; o_sum/o_max/o_min=3, then 9, then 4.

Source files
------------

// File: rtl/some_sub_module.sv
// some_sub_module: windowed sample statistics (saturating sum, max, min) over N_SAMPLES strobed samples
module some_sub_module #(
    parameter int W_ACC     = 12,
    parameter int N_SAMPLES = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             a,
    input  logic             b,
    input  logic [3:0]       c,
    output logic [W_ACC-1:0] o_sum,
    output logic [3:0]       o_max,
    output logic [3:0]       o_min,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_overflow
);
    typedef enum logic {IDLE, ACC} state_t;
    state_t state;
    logic [7:0] cnt;
    logic [7:0] next_cnt;
    logic [W_ACC-1:0] sum;
    logic [W_ACC-1:0] next_sum;
    logic [W_ACC:0] add;
    logic [3:0] max_r;
    logic [3:0] min_r;
    logic [3:0] next_max;
    logic [3:0] next_min;
    logic first;
    logic sat;
    logic done;
    always_comb begin
        first    = (state == IDLE);
        add      = (W_ACC+1)'(sum) + (W_ACC+1)'(c);
        sat      = !first && add[W_ACC];
        next_sum = first ? W_ACC'(c) : sat ? '1 : add[W_ACC-1:0];
        next_max = (first || c > max_r) ? c : max_r;
        next_min = (first || c < min_r) ? c : min_r;
        next_cnt = first ? 8'd1 : cnt + 8'd1;
        done     = (next_cnt == 8'(N_SAMPLES));
    end
    assign o_busy = (state == ACC);
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sum        <= '0;
            max_r      <= '0;
            min_r      <= '0;
            o_sum      <= '0;
            o_max      <= '0;
            o_min      <= '0;
            o_valid    <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (b) begin
                state      <= IDLE;
                cnt        <= '0;
                sum        <= '0;
                max_r      <= '0;
                min_r      <= '0;
                o_overflow <= 1'b0;
            end else if (a) begin
                if (sat)
                    o_overflow <= 1'b1;
                if (done) begin
                    // completed window publishes directly from the next-value logic
                    o_sum   <= next_sum;
                    o_max   <= next_max;
                    o_min   <= next_min;
                    o_valid <= 1'b1;
                    state   <= IDLE;
                    cnt     <= '0;
                end else begin
                    state <= ACC;
                    cnt   <= next_cnt;
                    sum   <= next_sum;
                    max_r <= next_max;
                    min_r <= next_min;
                end
            end
        end
    end
endmodule

// File: tb/tb_some_sub_module.sv
// tb_some_sub_module: scoreboard bench over default, narrow-accumulator and single-sample configurations
module tb_some_sub_module;
    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic b = 1'b0;
    logic [3:0] c = '0;
    logic a0 = 1'b0, a1 = 1'b0, a2 = 1'b0;
    logic [11:0] sum0, sum2;
    logic [5:0] sum1;
    logic [3:0] max0, min0, max1, min1, max2, min2;
    logic v0, v1, v2, busy0, busy1, busy2, ovf0, ovf1, ovf2;
    int checks = 0;
    int fails = 0;

    typedef struct {int s; int mx; int mn;} exp_t;
    exp_t q0[$], q1[$], q2[$];

    always #5 i_clk = ~i_clk;

    some_sub_module dut0 (.i_clk(i_clk), .i_rst(i_rst), .a(a0), .b(b), .c(c), .o_sum(sum0), .o_max(max0),
        .o_min(min0), .o_valid(v0), .o_busy(busy0), .o_overflow(ovf0));
    some_sub_module #(.W_ACC(6)) dut1 (.i_clk(i_clk), .i_rst(i_rst), .a(a1), .b(b), .c(c), .o_sum(sum1),
        .o_max(max1), .o_min(min1), .o_valid(v1), .o_busy(busy1), .o_overflow(ovf1));
    some_sub_module #(.N_SAMPLES(1)) dut2 (.i_clk(i_clk), .i_rst(i_rst), .a(a2), .b(b), .c(c), .o_sum(sum2),
        .o_max(max2), .o_min(min2), .o_valid(v2), .o_busy(busy2), .o_overflow(ovf2));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp(input string name, input exp_t e, input int s, input int mx, input int mn);
        chk({name, " sum"}, s, e.s);
        chk({name, " max"}, mx, e.mx);
        chk({name, " min"}, mn, e.mn);
    endtask

    function automatic exp_t mk(input int s, input int mx, input int mn);
        exp_t e;
        e.s = s; e.mx = mx; e.mn = mn;
        return e;
    endfunction

    // monitor: every valid pulse must match the oldest expected window
    always @(negedge i_clk) begin
        if (v0) begin
            if (q0.size() == 0) chk("dut0 unexpected valid", 1, 0);
            else cmp("dut0", q0.pop_front(), int'(sum0), int'(max0), int'(min0));
        end
        if (v1) begin
            if (q1.size() == 0) chk("dut1 unexpected valid", 1, 0);
            else cmp("dut1", q1.pop_front(), int'(sum1), int'(max1), int'(min1));
        end
        if (v2) begin
            if (q2.size() == 0) chk("dut2 unexpected valid", 1, 0);
            else cmp("dut2", q2.pop_front(), int'(sum2), int'(max2), int'(min2));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #2;
        end
    endtask

    task automatic send(input int k, input int v);
        c = 4'(v);
        if (k == 0) a0 = 1'b1; else if (k == 1) a1 = 1'b1; else a2 = 1'b1;
        step(1);
        a0 = 1'b0; a1 = 1'b0; a2 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        step(2);
        chk("reset sum", int'(sum0), 0);
        chk("reset busy", int'(busy0), 0);
        chk("reset valid", int'(v0), 0);
        i_rst = 1'b0;
        step(1);
        // consecutive samples 1..8
        q0.push_back(mk(36, 8, 1));
        for (int i = 1; i <= 8; i++) begin
            a0 = 1'b1; c = 4'(i);
            step(1);
            if (i == 1) chk("busy after first", int'(busy0), 1);
        end
        a0 = 1'b0;
        chk("busy with valid", int'(busy0), 0);
        chk("valid after 8th", int'(v0), 1);
        step(2);
        // asynchronous reset mid-window
        for (int i = 0; i < 3; i++) send(0, 9);
        chk("busy mid window", int'(busy0), 1);
        #1 i_rst = 1'b1;
        #1;
        chk("async rst sum", int'(sum0), 0);
        chk("async rst max", int'(max0), 0);
        chk("async rst min", int'(min0), 0);
        chk("async rst busy", int'(busy0), 0);
        step(1);
        i_rst = 1'b0;
        q0.push_back(mk(60, 11, 4));
        for (int i = 0; i < 8; i++) send(0, i + 4);
        step(2);
        // gapped strobe
        q0.push_back(mk(57, 15, 0));
        send(0, 15); step(1);
        send(0, 0); step(2);
        for (int i = 0; i < 6; i++) begin send(0, 7); step(1); end
        step(2);
        // abort with simultaneous strobe
        for (int i = 0; i < 5; i++) send(0, 5);
        b = 1'b1;
        send(0, 9);
        b = 1'b0;
        chk("abort busy", int'(busy0), 0);
        chk("abort keeps sum", int'(sum0), 57);
        chk("abort keeps max", int'(max0), 15);
        step(2);
        q0.push_back(mk(16, 2, 2));
        for (int i = 0; i < 8; i++) send(0, 2);
        step(2);
        // saturation on the narrow accumulator
        q1.push_back(mk(63, 15, 15));
        for (int i = 0; i < 8; i++) send(1, 15);
        chk("overflow set", int'(ovf1), 1);
        q1.push_back(mk(8, 1, 1));
        for (int i = 0; i < 8; i++) send(1, 1);
        chk("overflow sticky", int'(ovf1), 1);
        chk("no overflow dut0", int'(ovf0), 0);
        b = 1'b1;
        step(1);
        b = 1'b0;
        chk("overflow cleared", int'(ovf1), 0);
        step(1);
        // back-to-back single-sample windows
        q2.push_back(mk(3, 3, 3));
        q2.push_back(mk(9, 9, 9));
        q2.push_back(mk(4, 4, 4));
        a2 = 1'b1;
        c = 4'd3; step(1); chk("b2b valid 1", int'(v2), 1);
        c = 4'd9; step(1); chk("b2b valid 2", int'(v2), 1);
        c = 4'd4; step(1); chk("b2b valid 3", int'(v2), 1);
        a2 = 1'b0;
        step(1);
        chk("b2b valid drops", int'(v2), 0);
        chk("b2b busy", int'(busy2), 0);
        step(2);
        chk("dut0 pending", q0.size(), 0);
        chk("dut1 pending", q1.size(), 0);
        chk("dut2 pending", q2.size(), 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
